regbank_seq: RTL and testbench
==============================

// Module: regbank_seq
// PURPOSE
//   Sequencer driving the control/data ports of the 16x64 register bank. Accepts one micro-op at a time:
//   reads two operands into the bank's outA/outB registers, hands them to the ALU, waits for the result,
//   and writes it back. Also arbitrates a secondary external write port (loader/debug) onto the bank's
//   single write port. Sits between the instruction decoder, the register bank and the ALU.
// PARAMETERS
//   DW       64   data width (matches bank inA/outA/outB)
//   AW       4    register index width (16 registers)
//   TIMEOUT  255  max cycles in WAIT_RES before abort; 1..2^16-1
// PORTS
//   clock       in   1    master clock, posedge
//   reset       in   1    synchronous, active-high
//   op_valid    in   1    micro-op offered
//   op_ready    out  1    sequencer accepts micro-op (high only in IDLE)
//   op_srcA     in   AW   register for outA
//   op_srcB     in   AW   register for outB
//   op_cnstA    in   1    outA loads constant instead of register
//   op_cnstB    in   1    outB loads constant instead of register
//   op_dst      in   AW   write-back register
//   op_endreg   in   2    write-back field mode, passed to bank endreg
//   op_wb       in   1    1: write result back; 0: discard result
//   opnd_valid  out  1    bank outA/outB hold this op's operands
//   opnd_ready  in   1    ALU consumes operands
//   res_valid   in   1    ALU result offered
//   res_ready   out  1    high only in WAIT_RES
//   res_data    in   DW   ALU result
//   ext_req     in   1    external write request
//   ext_sel     in   AW   external write register
//   ext_endreg  in   2    external write field mode
//   ext_data    in   DW   external write data
//   ext_gnt     out  1    external write performed at this clock edge
//   regwe       out  1    to bank
//   selwreg     out  AW   to bank
//   endreg      out  2    to bank
//   inA         out  DW   to bank
//   seloutA     out  AW   to bank
//   seloutB     out  AW   to bank
//   cnstA       out  1    to bank
//   cnstB       out  1    to bank
//   enrregA     out  1    to bank
//   enrregB     out  1    to bank
//   busy        out  1    state != IDLE
//   timeout_err out  1    one-cycle pulse on WAIT_RES abort
//   op_count    out  16   completed ops (wraps 0xFFFF->0); aborted ops not counted
// BEHAVIOUR
//   - FSM: IDLE -> READ -> ISSUE -> WAIT_RES -> WB -> IDLE. Bank-facing outputs decode from the
//     registered state plus the latched op; no combinational path from op_* to bank ports.
//   - Reset: state=IDLE, latched op=0, timer=0, op_count=0, timeout_err=0. All outputs 0, except
//     op_ready=1.
//   - IDLE: op_ready=1. On op_valid, latch srcA/B, cnstA/B, dst, endreg, wb; go to READ.
//   - READ (1 cycle): enrregA=enrregB=1, seloutA/B and cnstA/B from the latched op. Go to ISSUE.
//   - ISSUE: opnd_valid=1 from the first ISSUE cycle. Hold until opnd_ready, then go to WAIT_RES
//     with timer cleared. Bank outputs are not reloaded while in ISSUE.
//   - WAIT_RES: res_ready=1. On res_valid, latch res_data: go to WB if wb=1, else IDLE (op_count+1).
//     Timer increments each cycle without res_valid. At timer==TIMEOUT-1 with no res_valid:
//     timeout_err=1 for that cycle, go to IDLE, no write, op_count unchanged.
//     res_valid on the final timeout cycle wins; no error.
//   - WB (1 cycle): regwe=1, selwreg=dst, endreg=latched endreg, inA=latched result;
//     op_count+1; go to IDLE.
//   - Accept-to-writeback minimum: op accepted cycle 0; READ cycle 1; opnd_valid cycle 2;
//     res_ready cycle 3 (opnd_ready same cycle as opnd_valid); WB cycle 4 (res_valid in cycle 3).
//   - External port: ext_gnt = ext_req & (state != WB). When granted, bank ports carry
//     regwe=1, selwreg=ext_sel, endreg=ext_endreg, inA=ext_data. WB always has priority;
//     a stalled ext_req must hold stable until ext_gnt.
//   - Ext write in the READ cycle to srcA/srcB: the bank reads the pre-write value (same edge).
//     No forwarding.
//   - Ext write to dst before WB: WB overwrites it (last write wins).
//   - Reset mid-op: abandons the op immediately; no regwe, no write-back, counter cleared.
//   - Reset asserted together with ext_req: no grant.
// TESTING
//   1. Bank reg3=0x5, reg7=0x9; op srcA=3, srcB=7, dst=1, wb=1, endreg=00; ALU returns 0xE ->
//      regwe pulses in cycle 4; reg1=0xE; op_count=1.
//   2. ext_req continuously, sel=2, data=0xAA, during op of test 1 -> ext_gnt=1 every cycle
//      except the WB cycle; reg2=0xAA; reg1=0xE.
//   3. Set TIMEOUT=4, never send res_valid -> timeout_err pulses exactly once, 4 cycles after
//      entering WAIT_RES; no regwe; op_count unchanged; op_ready=1 the next cycle.
//   4. opnd_ready held low for 10 cycles -> opnd_valid stays 1 and enrregA/B stay 0 throughout;
//      afterwards, normal completion.
//   5. op_wb=0, result 0x1234 -> no regwe; IDLE the cycle after the result; op_count+1.
//   6. reset asserted in WAIT_RES -> next cycle all outputs 0 except op_ready=1; a late res_valid
//      is ignored; no write.

Source files
------------

// File: rtl/regbank_seq.sv
// regbank_seq: sequences one micro-op at a time through the 16x64 register bank.
// The sequencer reads two operands, hands them to the ALU, waits for the result
// and writes it back. A secondary loader/debug write port shares the bank's
// single write port, and write-back always has priority over it.
module regbank_seq #(
  parameter int DW      = 64,
  parameter int AW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [AW-1:0] op_srcA,
  input  logic [AW-1:0] op_srcB,
  input  logic          op_cnstA,
  input  logic          op_cnstB,
  input  logic [AW-1:0] op_dst,
  input  logic [1:0]    op_endreg,
  input  logic          op_wb,
  output logic          opnd_valid,
  input  logic          opnd_ready,
  input  logic          res_valid,
  output logic          res_ready,
  input  logic [DW-1:0] res_data,
  input  logic          ext_req,
  input  logic [AW-1:0] ext_sel,
  input  logic [1:0]    ext_endreg,
  input  logic [DW-1:0] ext_data,
  output logic          ext_gnt,
  output logic          regwe,
  output logic [AW-1:0] selwreg,
  output logic [1:0]    endreg,
  output logic [DW-1:0] inA,
  output logic [AW-1:0] seloutA,
  output logic [AW-1:0] seloutB,
  output logic          cnstA,
  output logic          cnstB,
  output logic          enrregA,
  output logic          enrregB,
  output logic          busy,
  output logic          timeout_err,
  output logic [15:0]   op_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_t;

  // Last timer value before a pending result is abandoned.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t        r_state;
  logic [AW-1:0] r_srcA;
  logic [AW-1:0] r_srcB;
  logic          r_cnstA;
  logic          r_cnstB;
  logic [AW-1:0] r_dst;
  logic [1:0]    r_endreg;
  logic          r_wb;
  logic [DW-1:0] r_result;
  logic [15:0]   r_timer;
  logic [15:0]   r_opCount;
  logic          r_timeoutErr;

  logic          w_inWb;
  logic          w_extGnt;

  // Sequencer state machine: latches the op, walks it through read/issue/wait/write-back,
  // counts completed ops and raises the one-cycle timeout pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_srcA       <= '0;
      r_srcB       <= '0;
      r_cnstA      <= 1'b0;
      r_cnstB      <= 1'b0;
      r_dst        <= '0;
      r_endreg     <= '0;
      r_wb         <= 1'b0;
      r_result     <= '0;
      r_timer      <= '0;
      r_opCount    <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_timeoutErr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_srcA   <= op_srcA;
            r_srcB   <= op_srcB;
            r_cnstA  <= op_cnstA;
            r_cnstB  <= op_cnstB;
            r_dst    <= op_dst;
            r_endreg <= op_endreg;
            r_wb     <= op_wb;
            r_state  <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (opnd_ready) begin
            r_timer <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (res_valid) begin
            r_result <= res_data;
            if (r_wb) begin
              r_state <= S_WB;
            end else begin
              r_opCount <= r_opCount + 16'd1;
              r_state   <= S_IDLE;
            end
          end else if (r_timer == TIMER_LAST) begin
            r_timeoutErr <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_WB: begin
          r_opCount <= r_opCount + 16'd1;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_inWb   = (r_state == S_WB);
  assign w_extGnt = ext_req & ~reset & ~w_inWb;

  // Bank write port mux: write-back owns the port in WB, otherwise a granted external write.
  always_comb begin
    regwe   = 1'b0;
    selwreg = '0;
    endreg  = '0;
    inA     = '0;
    if (w_inWb && !reset) begin
      regwe   = 1'b1;
      selwreg = r_dst;
      endreg  = r_endreg;
      inA     = r_result;
    end else if (w_extGnt) begin
      regwe   = 1'b1;
      selwreg = ext_sel;
      endreg  = ext_endreg;
      inA     = ext_data;
    end
  end

  assign ext_gnt     = w_extGnt;
  assign seloutA     = r_srcA;
  assign seloutB     = r_srcB;
  assign cnstA       = r_cnstA;
  assign cnstB       = r_cnstB;
  assign enrregA     = (r_state == S_READ);
  assign enrregB     = (r_state == S_READ);
  assign op_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign opnd_valid  = (r_state == S_ISSUE);
  assign res_ready   = (r_state == S_WAIT);
  assign timeout_err = r_timeoutErr;
  assign op_count    = r_opCount;

endmodule

// File: tb/tb_regbank_seq.sv
// tb_regbank_seq: exercises regbank_seq against a small register bank and ALU
// living in the bench, plus a transaction-level reference of the bank contents.
module tb_regbank_seq;

  localparam int DW   = 64;
  localparam int AW   = 4;
  localparam int TOUT = 4;
  localparam logic [63:0] CONSTV = 64'h0000_0000_0000_0100;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          clock = 1'b0;
  logic          reset;
  logic          op_valid;
  logic          op_ready;
  logic [AW-1:0] op_srcA;
  logic [AW-1:0] op_srcB;
  logic          op_cnstA;
  logic          op_cnstB;
  logic [AW-1:0] op_dst;
  logic [1:0]    op_endreg;
  logic          op_wb;
  logic          opnd_valid;
  logic          opnd_ready;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          ext_req;
  logic [AW-1:0] ext_sel;
  logic [1:0]    ext_endreg;
  logic [DW-1:0] ext_data;
  logic          ext_gnt;
  logic          regwe;
  logic [AW-1:0] selwreg;
  logic [1:0]    endreg;
  logic [DW-1:0] inA;
  logic [AW-1:0] seloutA;
  logic [AW-1:0] seloutB;
  logic          cnstA;
  logic          cnstB;
  logic          enrregA;
  logic          enrregB;
  logic          busy;
  logic          timeout_err;
  logic [15:0]   op_count;

  int nVec = 0;
  int nErr = 0;

  logic [63:0] bank [16];
  logic [63:0] bOutA;
  logic [63:0] bOutB;
  logic [63:0] refBank [16];
  logic [15:0] refCount;

  typedef struct {
    logic        opV;
    logic        opnR;
    logic        resV;
    logic        extR;
    logic        eOpReady;
    logic        eBusy;
    logic        eEnr;
    logic        eOpndV;
    logic        eResR;
    logic        eRegwe;
    logic        eGnt;
    logic [3:0]  eSelw;
    logic [15:0] eCnt;
  } vec_t;

  vec_t tbl [12];

  regbank_seq #(.DW(DW), .AW(AW), .TIMEOUT(TOUT)) dut (
    .clock(clock), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_srcA(op_srcA), .op_srcB(op_srcB), .op_cnstA(op_cnstA), .op_cnstB(op_cnstB),
    .op_dst(op_dst), .op_endreg(op_endreg), .op_wb(op_wb),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .ext_req(ext_req), .ext_sel(ext_sel), .ext_endreg(ext_endreg), .ext_data(ext_data),
    .ext_gnt(ext_gnt),
    .regwe(regwe), .selwreg(selwreg), .endreg(endreg), .inA(inA),
    .seloutA(seloutA), .seloutB(seloutB), .cnstA(cnstA), .cnstB(cnstB),
    .enrregA(enrregA), .enrregB(enrregB),
    .busy(busy), .timeout_err(timeout_err), .op_count(op_count)
  );

  always #5 clock = ~clock;

  // Register bank stand-in: one write port, two output registers loaded on enrreg.
  always @(posedge clock) begin
    if (regwe) bank[selwreg] <= inA;
    if (enrregA) bOutA <= cnstA ? CONSTV : bank[seloutA];
    if (enrregB) bOutB <= cnstB ? CONSTV : bank[seloutB];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    op_valid   = v.opV;
    opnd_ready = v.opnR;
    res_valid  = v.resV;
    ext_req    = v.extR;
    res_data   = bOutA + bOutB;
  endtask

  task automatic extWrite(input logic [3:0] sel, input logic [63:0] data);
    ext_req    = 1'b1;
    ext_sel    = sel;
    ext_data   = data;
    ext_endreg = 2'b00;
    @(negedge clock);
    checkOutput("preload_gnt", 64'(ext_gnt), 64'(1'b1));
    nextCycle();
    ext_req      = 1'b0;
    refBank[sel] = data;
  endtask

  // One op driven from a plan: d extra ISSUE cycles, result in WAIT cycle r (r >= TOUT: never).
  task automatic runOp(input logic [3:0] sA, input logic [3:0] sB, input logic cA, input logic cB,
                       input logic [3:0] dst, input logic [1:0] er, input logic wb,
                       input int d, input int r, input int extRate);
    int w, len, wbCyc, lastWait;
    logic hit, isWb, extExp, pend;
    logic [3:0] pSel;
    logic [63:0] pData, expA, expB;
    logic [1:0] pEr;
    w        = 3 + d;
    hit      = (r < TOUT);
    lastWait = hit ? w + r : w + TOUT - 1;
    wbCyc    = (hit && wb) ? w + r + 1 : -1;
    len      = (hit && wb) ? w + r + 2 : lastWait + 1;
    pend = 1'b0; pSel = '0; pData = '0; pEr = '0; expA = '0; expB = '0;
    for (int c = 0; c <= len; c++) begin
      if (c == 0) begin
        op_valid = 1'b1; op_srcA = sA; op_srcB = sB; op_cnstA = cA; op_cnstB = cB;
        op_dst = dst; op_endreg = er; op_wb = wb;
      end else begin
        op_valid = (c < len) ? 1'($urandom_range(0, 1)) : 1'b0;
        op_srcA = 4'($urandom); op_srcB = 4'($urandom); op_dst = 4'($urandom);
        op_cnstA = 1'($urandom); op_cnstB = 1'($urandom); op_wb = 1'($urandom);
        op_endreg = 2'($urandom);
      end
      opnd_ready = (c == 2 + d);
      res_valid  = hit && (c == w + r);
      if (!pend && $urandom_range(0, 99) < extRate) begin
        pend = 1'b1; pSel = 4'($urandom); pData = {$urandom, $urandom}; pEr = 2'($urandom);
      end
      ext_req = pend; ext_sel = pSel; ext_data = pData; ext_endreg = pEr;
      isWb   = (c == wbCyc);
      extExp = pend && !isWb;
      if (c == 1) begin
        expA = cA ? CONSTV : refBank[sA];
        expB = cB ? CONSTV : refBank[sB];
      end
      res_data = bOutA + bOutB;
      @(negedge clock);
      checkOutput($sformatf("op_ready c%0d", c), 64'(op_ready), 64'(c == 0 || c == len));
      checkOutput($sformatf("busy c%0d", c), 64'(busy), 64'(!(c == 0 || c == len)));
      checkOutput($sformatf("enrregA c%0d", c), 64'(enrregA), 64'(c == 1));
      checkOutput($sformatf("enrregB c%0d", c), 64'(enrregB), 64'(c == 1));
      checkOutput($sformatf("opnd_valid c%0d", c), 64'(opnd_valid), 64'(c >= 2 && c <= 2 + d));
      checkOutput($sformatf("res_ready c%0d", c), 64'(res_ready), 64'(c >= w && c <= lastWait));
      checkOutput($sformatf("timeout_err c%0d", c), 64'(timeout_err), 64'(!hit && c == len));
      checkOutput($sformatf("ext_gnt c%0d", c), 64'(ext_gnt), 64'(extExp));
      checkOutput($sformatf("regwe c%0d", c), 64'(regwe), 64'(isWb || extExp));
      if (c == 1) begin
        checkOutput("seloutA", 64'(seloutA), 64'(sA));
        checkOutput("seloutB", 64'(seloutB), 64'(sB));
      end
      if (isWb) begin
        checkOutput("wb_selwreg", 64'(selwreg), 64'(dst));
        checkOutput("wb_endreg", 64'(endreg), 64'(er));
        checkOutput("wb_inA", inA, expA + expB);
      end else if (extExp) begin
        checkOutput("ext_selwreg", 64'(selwreg), 64'(pSel));
        checkOutput("ext_endreg", 64'(endreg), 64'(pEr));
        checkOutput("ext_inA", inA, pData);
      end
      if (c == len) checkOutput("op_count", 64'(op_count), 64'(refCount));
      nextCycle();
      if (extExp) begin
        refBank[pSel] = pData;
        pend = 1'b0;
      end
      if (isWb) refBank[dst] = expA + expB;
      if (hit && c == (wb ? wbCyc : w + r)) refCount = refCount + 16'd1;
    end
    op_valid = 1'b0; opnd_ready = 1'b0; res_valid = 1'b0; ext_req = 1'b0;
  endtask

  initial begin
    // Cycle-by-cycle trace of a minimal op, first alone, then with a continuous ext request.
    tbl[0]  = '{H, L, L, L,  H, L, L, L, L, L, L, 4'd0, 16'd0};
    tbl[1]  = '{L, L, L, L,  L, H, H, L, L, L, L, 4'd0, 16'd0};
    tbl[2]  = '{L, H, L, L,  L, H, L, H, L, L, L, 4'd0, 16'd0};
    tbl[3]  = '{L, L, H, L,  L, H, L, L, H, L, L, 4'd0, 16'd0};
    tbl[4]  = '{L, L, L, L,  L, H, L, L, L, H, L, 4'd1, 16'd0};
    tbl[5]  = '{L, L, L, L,  H, L, L, L, L, L, L, 4'd0, 16'd1};
    tbl[6]  = '{H, L, L, H,  H, L, L, L, L, H, H, 4'd2, 16'd1};
    tbl[7]  = '{L, L, L, H,  L, H, H, L, L, H, H, 4'd2, 16'd1};
    tbl[8]  = '{L, H, L, H,  L, H, L, H, L, H, H, 4'd2, 16'd1};
    tbl[9]  = '{L, L, H, H,  L, H, L, L, H, H, H, 4'd2, 16'd1};
    tbl[10] = '{L, L, L, H,  L, H, L, L, L, H, L, 4'd1, 16'd1};
    tbl[11] = '{L, L, L, H,  H, L, L, L, L, H, H, 4'd2, 16'd2};

    reset = 1'b1; op_valid = 1'b0; op_srcA = '0; op_srcB = '0; op_cnstA = 1'b0; op_cnstB = 1'b0;
    op_dst = '0; op_endreg = '0; op_wb = 1'b0; opnd_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    ext_req = 1'b1; ext_sel = 4'd3; ext_endreg = 2'b01; ext_data = 64'hDEAD;
    refCount = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_op_ready", 64'(op_ready), 64'(1'b1));
    checkOutput("rst_busy", 64'(busy), 64'(1'b0));
    checkOutput("rst_regwe", 64'(regwe), 64'(1'b0));
    checkOutput("rst_ext_gnt", 64'(ext_gnt), 64'(1'b0));
    checkOutput("rst_op_count", 64'(op_count), 64'(16'd0));
    checkOutput("rst_timeout_err", 64'(timeout_err), 64'(1'b0));
    checkOutput("rst_enrregA", 64'(enrregA), 64'(1'b0));
    nextCycle();
    reset = 1'b0; ext_req = 1'b0;

    for (int i = 0; i < 16; i++) extWrite(4'(i), {$urandom, $urandom});
    extWrite(4'd3, 64'h5);
    extWrite(4'd7, 64'h9);

    op_srcA = 4'd3; op_srcB = 4'd7; op_cnstA = 1'b0; op_cnstB = 1'b0;
    op_dst = 4'd1; op_endreg = 2'b00; op_wb = 1'b1;
    ext_sel = 4'd2; ext_data = 64'hAA; ext_endreg = 2'b00;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i]);
      @(negedge clock);
      checkOutput($sformatf("tbl%0d op_ready", i), 64'(op_ready), 64'(tbl[i].eOpReady));
      checkOutput($sformatf("tbl%0d busy", i), 64'(busy), 64'(tbl[i].eBusy));
      checkOutput($sformatf("tbl%0d enrregA", i), 64'(enrregA), 64'(tbl[i].eEnr));
      checkOutput($sformatf("tbl%0d opnd_valid", i), 64'(opnd_valid), 64'(tbl[i].eOpndV));
      checkOutput($sformatf("tbl%0d res_ready", i), 64'(res_ready), 64'(tbl[i].eResR));
      checkOutput($sformatf("tbl%0d regwe", i), 64'(regwe), 64'(tbl[i].eRegwe));
      checkOutput($sformatf("tbl%0d ext_gnt", i), 64'(ext_gnt), 64'(tbl[i].eGnt));
      checkOutput($sformatf("tbl%0d selwreg", i), 64'(selwreg), 64'(tbl[i].eSelw));
      checkOutput($sformatf("tbl%0d op_count", i), 64'(op_count), 64'(tbl[i].eCnt));
      nextCycle();
    end
    op_valid = 1'b0; opnd_ready = 1'b0; res_valid = 1'b0; ext_req = 1'b0;
    checkOutput("tbl_reg1", bank[1], 64'hE);
    checkOutput("tbl_reg2", bank[2], 64'hAA);
    refBank[1] = 64'hE;
    refBank[2] = 64'hAA;
    refCount   = 16'd2;

    runOp(4'd3, 4'd7, 1'b0, 1'b0, 4'd9, 2'b01, 1'b1, 0, TOUT, 0);
    runOp(4'd3, 4'd7, 1'b0, 1'b0, 4'd9, 2'b10, 1'b1, 10, 1, 0);
    runOp(4'd7, 4'd3, 1'b1, 1'b0, 4'd10, 2'b00, 1'b0, 0, 0, 0);
    runOp(4'd1, 4'd2, 1'b0, 1'b1, 4'd11, 2'b11, 1'b1, 0, TOUT - 1, 40);

    // Reset while waiting for the ALU result, with an external request pending.
    op_valid = 1'b1; op_srcA = 4'd1; op_srcB = 4'd2; op_cnstA = 1'b0; op_cnstB = 1'b0;
    op_dst = 4'd5; op_endreg = 2'b00; op_wb = 1'b1;
    nextCycle();
    op_valid = 1'b0;
    nextCycle();
    opnd_ready = 1'b1;
    nextCycle();
    opnd_ready = 1'b0;
    reset = 1'b1; ext_req = 1'b1; ext_sel = 4'd6; ext_data = 64'hBAD;
    @(negedge clock);
    checkOutput("rstmid_ext_gnt", 64'(ext_gnt), 64'(1'b0));
    checkOutput("rstmid_regwe", 64'(regwe), 64'(1'b0));
    nextCycle();
    reset = 1'b0; ext_req = 1'b0;
    @(negedge clock);
    checkOutput("rstpost_op_ready", 64'(op_ready), 64'(1'b1));
    checkOutput("rstpost_busy", 64'(busy), 64'(1'b0));
    checkOutput("rstpost_res_ready", 64'(res_ready), 64'(1'b0));
    checkOutput("rstpost_op_count", 64'(op_count), 64'(16'd0));
    checkOutput("rstpost_seloutA", 64'(seloutA), 64'(4'd0));
    checkOutput("rstpost_timeout_err", 64'(timeout_err), 64'(1'b0));
    nextCycle();
    res_valid = 1'b1; res_data = 64'h1234;
    @(negedge clock);
    checkOutput("late_res_regwe", 64'(regwe), 64'(1'b0));
    nextCycle();
    res_valid = 1'b0;
    @(negedge clock);
    checkOutput("late_res_busy", 64'(busy), 64'(1'b0));
    checkOutput("late_res_regwe2", 64'(regwe), 64'(1'b0));
    nextCycle();
    refCount = 16'd0;

    for (int k = 0; k < 80; k++) begin
      runOp(4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            4'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 3)), int'($urandom_range(0, TOUT)), int'($urandom_range(0, 60)));
    end

    for (int i = 0; i < 16; i++) checkOutput($sformatf("bank%0d", i), bank[i], refBank[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
